// File: rtl/set_pkg.sv
// Shared types and constants for the SET engine job arbiter: operand field
// widths, set-operation encodings, sequencer states and the job record.
package set_pkg;

  localparam int COORD_W   = 4;
  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int MODE_W    = 2;

  typedef enum logic [1:0] {
    MODE_A        = 2'b00,
    MODE_AND      = 2'b01,
    MODE_XOR      = 2'b10,
    MODE_TWO_OF_3 = 2'b11
  } set_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    RUN,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [MODE_W-1:0]    mode;
  } set_job_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/set_rr_arb2.sv
// Two-way round-robin grant. On a tie the requester that was not granted
// last wins; a lone request is always granted.
module set_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       arb_en,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Requester favoured on the next tie; starts with requester 0.
  logic prio_reg;

  always_comb begin
    grant_idx = 1'b0;
    if (req == 2'b11) begin
      grant_idx = prio_reg;
    end else begin
      grant_idx = req[1];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = arb_en & req[gi] & (grant_idx == 1'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_reg <= 1'b0;
    end else if (accept) begin
      prio_reg <= ~grant_idx;
    end
  end

endmodule

// File: rtl/set_job_arbiter.sv
// Shares one SET candidate-counting engine between two requesters, one job
// at a time. Define SET_TIMEOUT_EN to add a launch-to-result watchdog.
module set_job_arbiter
  import set_pkg::*;
#(
  parameter int CAND_W = 8
`ifdef SET_TIMEOUT_EN
  ,
  parameter int TMO_CYCLES = 2048
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [CENTRAL_W-1:0] req_central0,
  input  logic [CENTRAL_W-1:0] req_central1,
  input  logic [RADIUS_W-1:0]  req_radius0,
  input  logic [RADIUS_W-1:0]  req_radius1,
  input  logic [MODE_W-1:0]    req_mode0,
  input  logic [MODE_W-1:0]    req_mode1,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [CAND_W-1:0]    resp_candidate,
  output logic                 resp_err,
  output logic                 eng_en,
  output logic [CENTRAL_W-1:0] eng_central,
  output logic [RADIUS_W-1:0]  eng_radius,
  output logic [MODE_W-1:0]    eng_mode,
  input  logic                 eng_busy,
  input  logic                 eng_valid,
  input  logic [CAND_W-1:0]    eng_candidate,
  output logic                 grant_id
);

  arb_state_e          state_reg, state_next;
  set_job_t            job_reg, job_sel;
  logic                grant_id_reg;
  logic [CAND_W-1:0]   cand_reg;
  logic [1:0]          grant;
  logic                grant_idx;
  logic                arb_en;
  logic                accept;
  logic                waiting;
  logic                tmo_hit;

  // A busy engine blocks new work even in IDLE: it may still be finishing
  // a job that was abandoned by reset or by the watchdog.
  assign arb_en  = (state_reg == IDLE) && !eng_busy;
  assign accept  = |(req_valid & grant);
  assign waiting = (state_reg == WAIT_BUSY) || (state_reg == RUN);

  set_rr_arb2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .arb_en    (arb_en),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    job_sel = '{central: req_central0, radius: req_radius0, mode: req_mode0};
    if (grant_idx) begin
      job_sel = '{central: req_central1, radius: req_radius1, mode: req_mode1};
    end
  end

  always_comb begin
    state_next = state_reg;
    eng_en     = 1'b0;
    resp_valid = 2'b00;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = LAUNCH;
      end
      LAUNCH: begin
        eng_en     = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tmo_hit)       state_next = RESP;
        else if (eng_busy) state_next = RUN;
      end
      RUN: begin
        if (eng_valid || tmo_hit) state_next = RESP;
      end
      RESP: begin
        resp_valid = onehot2(grant_id_reg);
        if (resp_ready[grant_id_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      job_reg      <= '0;
      grant_id_reg <= 1'b0;
      cand_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        job_reg      <= job_sel;
        grant_id_reg <= grant_idx;
      end
      // Engine strobes outside RUN belong to no live job and are dropped.
      if (state_reg == RUN && eng_valid) begin
        cand_reg <= eng_candidate;
      end else if (waiting && tmo_hit) begin
        cand_reg <= '0;
      end
    end
  end

`ifdef SET_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             err_reg;

  assign tmo_hit = waiting && (tmo_cnt_reg == TMO_W'(TMO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (state_reg == LAUNCH) begin
        tmo_cnt_reg <= '0;
      end else if (waiting) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
      if (accept) begin
        err_reg <= 1'b0;
      end else if (state_reg == RUN && eng_valid) begin
        err_reg <= 1'b0;
      end else if (tmo_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign resp_err = err_reg;
`else
  assign tmo_hit  = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign req_ready      = grant;
  assign resp_candidate = cand_reg;
  assign eng_central    = job_reg.central;
  assign eng_radius     = job_reg.radius;
  assign eng_mode       = job_reg.mode;
  assign grant_id       = grant_id_reg;

endmodule

// File: tb/tb_set_job_arbiter.sv
// Randomized bench for set_job_arbiter with a behavioural SET engine stub and
// a job-level reference model; define SET_TIMEOUT_EN to exercise the watchdog.
module tb_set_job_arbiter;

  localparam int CAND_W = 8;
`ifdef SET_TIMEOUT_EN
  localparam int TMO = 16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        req_valid, req_ready, resp_valid, resp_ready;
  logic [23:0]       cen [2];
  logic [11:0]       rad [2];
  logic [1:0]        mod [2];
  logic [CAND_W-1:0] resp_candidate;
  logic              resp_err, eng_en, grant_id;
  logic [23:0]       eng_central;
  logic [11:0]       eng_radius;
  logic [1:0]        eng_mode;
  logic              eng_busy, eng_valid;
  logic [CAND_W-1:0] eng_candidate;

  set_job_arbiter #(
    .CAND_W(CAND_W)
`ifdef SET_TIMEOUT_EN
    , .TMO_CYCLES(TMO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_central0(cen[0]), .req_central1(cen[1]),
    .req_radius0(rad[0]), .req_radius1(rad[1]),
    .req_mode0(mod[0]), .req_mode1(mod[1]),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_candidate(resp_candidate), .resp_err(resp_err),
    .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius),
    .eng_mode(eng_mode), .eng_busy(eng_busy), .eng_valid(eng_valid),
    .eng_candidate(eng_candidate), .grant_id(grant_id)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference SET semantics on the 16x16 grid.
  function automatic bit in_circle(input int x, input int y, input logic [3:0] cx,
                                   input logic [3:0] cy, input logic [3:0] r);
    int dx, dy;
    dx = x - int'(cx);
    dy = y - int'(cy);
    return (dx * dx + dy * dy) <= (int'(r) * int'(r));
  endfunction

  function automatic logic [7:0] count_set(input logic [23:0] c, input logic [11:0] r,
                                           input logic [1:0] m);
    int n = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        bit a, b, k, hit;
        a = in_circle(x, y, c[23:20], c[19:16], r[11:8]);
        b = in_circle(x, y, c[15:12], c[11:8], r[7:4]);
        k = in_circle(x, y, c[7:4], c[3:0], r[3:0]);
        case (m)
          2'b00:   hit = a;
          2'b01:   hit = a & b;
          2'b10:   hit = a ^ b;
          default: hit = ((int'(a) + int'(b) + int'(k)) == 2);
        endcase
        if (hit) n++;
      end
    end
    return 8'(n);
  endfunction

  // Engine stub: starts 0-2 cycles after eng_en, stays busy, then strobes a
  // result computed from the operands it sees at the end of the run.
  int eng_st  = 0;
  int eng_cnt = 0;
  int run_max = 20;
  bit en_pend = 0, eng_real = 0, eng_hang = 0;

  initial begin
    eng_busy = 1'b0; eng_valid = 1'b0; eng_candidate = '0;
`ifdef SET_TIMEOUT_EN
    run_max = 10;
`endif
    forever begin
      @(posedge clk); #1;
      eng_valid = 1'b0;
      eng_real  = 1'b0;
      if (eng_st == 0 && en_pend) begin
        eng_cnt = $urandom_range(0, 2);
        eng_st  = 1;
      end
      if (eng_st == 1) begin
        if (eng_cnt == 0) begin
          eng_busy = 1'b1;
          eng_st   = 2;
          eng_cnt  = $urandom_range(2, run_max);
        end else eng_cnt--;
      end else if (eng_st == 2) begin
        if (!eng_hang) begin
          if (eng_cnt == 0) begin
            eng_valid     = 1'b1;
            eng_real      = 1'b1;
            eng_candidate = count_set(eng_central, eng_radius, eng_mode);
            eng_busy      = 1'b0;
            eng_st        = 0;
          end else eng_cnt--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        eng_valid     = 1'b1;
        eng_candidate = 8'($urandom);
      end
      en_pend = eng_en;
    end
  end

  // Job-level reference model, evaluated at the negative edge.
  typedef struct { logic id; logic [23:0] c; logic [11:0] r; logic [1:0] m; } job_t;
  job_t       m_job;
  bit         m_busy = 0, m_resp = 0, m_last = 1, m_en_now = 0, m_rst_seen = 0, m_err = 0;
  logic [7:0] m_cand = '0;
  int         m_wait = 0;
  logic [1:0] acc_flag = '0;

  always @(negedge clk) begin
    logic [1:0] exp_rdy, exp_rv;
    bit launch_cycle;
    if (!rst_n) begin
      if (m_busy) $display("job from requester %0d abandoned by reset", m_job.id);
      m_busy = 0; m_resp = 0; m_last = 1; m_en_now = 0; m_rst_seen = 1;
      m_wait = 0; acc_flag = '0;
    end else begin
      if (m_rst_seen) begin
        check_val("rst_resp_valid", resp_valid, 2'b00);
        check_val("rst_resp_err", resp_err, 1'b0);
        check_val("rst_eng_en", eng_en, 1'b0);
        check_val("rst_eng_central", eng_central, 24'h0);
        check_val("rst_eng_radius", eng_radius, 12'h0);
        check_val("rst_eng_mode", eng_mode, 2'b00);
        check_val("rst_candidate", resp_candidate, 8'h0);
        check_val("rst_grant_id", grant_id, 1'b0);
        m_rst_seen = 0;
      end
      exp_rdy = 2'b00;
      if (!m_busy && !eng_busy) begin
        if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
        else exp_rdy = req_valid;
      end
      check_val("req_ready", req_ready, exp_rdy);
      check_val("eng_en", eng_en, m_en_now);
      exp_rv = m_resp ? (m_job.id ? 2'b10 : 2'b01) : 2'b00;
      check_val("resp_valid", resp_valid, exp_rv);
      if (m_resp) begin
        check_val("resp_candidate", resp_candidate, m_cand);
        check_val("resp_err", resp_err, m_err);
      end
      if (m_busy) begin
        check_val("grant_id", grant_id, m_job.id);
        check_val("eng_central", eng_central, m_job.c);
        check_val("eng_radius", eng_radius, m_job.r);
        check_val("eng_mode", eng_mode, m_job.m);
      end
      acc_flag     = req_valid & req_ready;
      launch_cycle = m_en_now;
      m_en_now     = 0;
      if (m_resp && resp_ready[m_job.id]) begin
        $display("job from requester %0d returned candidate %0d err %0d",
                 m_job.id, m_cand, m_err);
        m_resp = 0;
        m_busy = 0;
      end else if (m_busy && !m_resp && !launch_cycle) begin
        if (eng_valid && eng_real) begin
          m_resp = 1;
          m_cand = count_set(m_job.c, m_job.r, m_job.m);
          m_err  = 0;
        end
`ifdef SET_TIMEOUT_EN
        else if (m_wait == TMO - 1) begin
          m_resp = 1;
          m_cand = '0;
          m_err  = 1;
        end else m_wait++;
`endif
      end
      if ((exp_rdy & req_valid) != 2'b00) begin
        m_busy   = 1;
        m_job.id = exp_rdy[1];
        m_job.c  = cen[exp_rdy[1]];
        m_job.r  = rad[exp_rdy[1]];
        m_job.m  = mod[exp_rdy[1]];
        m_last   = exp_rdy[1];
        m_en_now = 1;
        m_wait   = 0;
      end
    end
  end

  // Requester / response-sink stimulus knobs.
  bit [1:0] en_req = '0, hold_nrdy = '0;
  int p_req = 0, p_b2b = 0, p_rdy = 100, p_jit = 0;

  task automatic rand_ops(input int i);
    cen[i] = 24'($urandom);
    rad[i] = 12'($urandom);
    mod[i] = 2'($urandom);
  endtask

  task automatic drive_step();
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && acc_flag[i]) begin
        rand_ops(i);
        if (!(en_req[i] && $urandom_range(0, 99) < p_b2b)) req_valid[i] = 1'b0;
      end else if (req_valid[i]) begin
        if ($urandom_range(0, 99) < p_jit) rand_ops(i);
      end else if (en_req[i] && $urandom_range(0, 99) < p_req) begin
        rand_ops(i);
        req_valid[i] = 1'b1;
      end
      resp_ready[i] = !hold_nrdy[i] && ($urandom_range(0, 99) < p_rdy);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive_step();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int k;
    rst_n = 1'b0; req_valid = '0; resp_ready = '0;
    for (int i = 0; i < 2; i++) begin cen[i] = '0; rad[i] = '0; mod[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run(2);

    // Single directed job from requester 0: disc of radius 3 at (4,4).
    cen[0] = 24'h440000; rad[0] = 12'h300; mod[0] = 2'b00; req_valid[0] = 1'b1;
    k = 0;
    while (!resp_valid[0] && k < 300) begin step(); k++; end
    check_val("t1_resp_seen", resp_valid[0], 1'b1);
    check_val("t1_candidate", resp_candidate, 8'd29);
    check_val("t1_other_valid", resp_valid[1], 1'b0);
    run(5);

    // Both requesters saturated, sink always ready.
    en_req = 2'b11; p_req = 100; p_b2b = 100; p_rdy = 100; p_jit = 0;
    run(400);

    // Long backpressure on requester 0's response.
    k = 0;
    while (!resp_valid[0] && k < 400) begin step(); k++; end
    check_val("bp_resp_seen", resp_valid[0], 1'b1);
    hold_nrdy[0] = 1'b1; resp_ready[0] = 1'b0;
    run(50);
    hold_nrdy[0] = 1'b0;
    run(100);

    // Random mix with operand jitter while waiting and after accept.
    p_req = 40; p_b2b = 50; p_rdy = 60; p_jit = 25;
    run(1500);

    // Reset in the middle of an engine run; engine keeps going.
    k = 0;
    while (!(eng_st == 2 && eng_cnt >= 4 && !eng_hang) && k < 500) begin step(); k++; end
    check_val("rst_window_busy", eng_busy, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(300);

    // Engine stalls busy with no result for 60 cycles.
    en_req = 2'b00; p_rdy = 100;
    run(80);
    eng_hang = 1'b1;
    en_req = 2'b11; p_req = 100;
    run(60);
    eng_hang = 1'b0;
    p_rdy = 70;
    run(300);

    en_req = 2'b00; p_rdy = 100;
    run(60);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
